// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a byte-enabled BRAM port.
// Define MEM_ACCESS_MISALIGN_EXC_EN to raise o_exc on misaligned accesses.
module mem_access_unit #(
    parameter int NB_DATA     = 32,
    parameter int RAM_DEPTH   = 2048,
    parameter int MEM_LATENCY = 2,
    localparam int AW         = $clog2(RAM_DEPTH - 1)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_we,
    input  logic [2:0]         i_op,
    input  logic [31:0]        i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_rvalid,
    output logic               o_done,
    output logic               o_exc,
    output logic [31:0]        o_badaddr,
    output logic [AW-1:0]      o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wdata,
    output logic [3:0]         o_mem_we,
    output logic               o_mem_en,
    output logic               o_mem_rea,
    input  logic [NB_DATA-1:0] i_mem_rdata
);

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t state, next;

    logic               r_we, r_b, r_h, r_uns, r_exc;
    logic [31:0]        r_addr;
    logic [NB_DATA-1:0] r_wdata;
    logic [2:0]         cnt;

    logic               in_b, in_h, in_mis;
    logic [31:0]        in_addr;
    logic [3:0]         st_we;
    logic [NB_DATA-1:0] st_wdata;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [NB_DATA-1:0] ld_data;

    // Undefined size encodings fall through to word.
    assign in_b   = (i_op[1:0] == 2'b00);
    assign in_h   = (i_op[1:0] == 2'b01);
    assign in_mis = in_h ? i_addr[0] : (!in_b && (i_addr[1:0] != 2'b00));

    // Without exceptions, misaligned low bits are simply dropped.
    always_comb begin
        in_addr = i_addr;
        if (!EXC_EN && in_h) begin
            in_addr[0] = 1'b0;
        end else if (!EXC_EN && !in_b) begin
            in_addr[1:0] = 2'b00;
        end
    end

    always_comb begin
        st_we    = 4'b1111;
        st_wdata = r_wdata;
        if (r_b) begin
            st_we    = 4'b0001 << r_addr[1:0];
            st_wdata = {4{r_wdata[7:0]}};
        end else if (r_h) begin
            st_we    = 4'b0011 << r_addr[1:0];
            st_wdata = {2{r_wdata[15:0]}};
        end
    end

    always_comb begin
        ld_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        ld_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        ld_data = i_mem_rdata;
        if (r_b) begin
            ld_data = {{24{ld_byte[7] & ~r_uns}}, ld_byte};
        end else if (r_h) begin
            ld_data = {{16{ld_half[15] & ~r_uns}}, ld_half};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            r_we    <= 1'b0;
            r_b     <= 1'b0;
            r_h     <= 1'b0;
            r_uns   <= 1'b0;
            r_exc   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            cnt     <= '0;
            o_rdata <= '0;
        end else begin
            state <= next;
            if (state == S_IDLE && i_valid) begin
                r_we    <= i_we;
                r_b     <= in_b;
                r_h     <= in_h;
                r_uns   <= i_op[2];
                r_exc   <= EXC_EN && in_mis;
                r_addr  <= in_addr;
                r_wdata <= i_wdata;
            end
            if (state == S_ISSUE) begin
                cnt <= CNT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (state == S_CAPT) begin
                o_rdata <= ld_data;
            end
        end
    end

    always_comb begin
        next        = state;
        o_ready     = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_rea   = 1'b0;
        o_mem_we    = '0;
        o_mem_wdata = '0;
        o_rvalid    = 1'b0;
        o_done      = 1'b0;
        o_exc       = 1'b0;
        unique case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    next = (EXC_EN && in_mis) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_en = 1'b1;
                if (r_we) begin
                    o_mem_we    = st_we;
                    o_mem_wdata = st_wdata;
                    next        = S_DONE;
                end else begin
                    next = (MEM_LATENCY == 1) ? S_CAPT : S_WAIT;
                end
            end
            S_WAIT: begin
                o_mem_en  = 1'b1;
                o_mem_rea = 1'b1;
                if (cnt == 3'd1) begin
                    next = S_CAPT;
                end
            end
            S_CAPT: begin
                next = S_DONE;
            end
            S_DONE: begin
                o_rvalid = ~r_we & ~r_exc;
                o_done   = r_we & ~r_exc;
                o_exc    = r_exc;
                next     = S_IDLE;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

    assign o_mem_addr = r_addr[AW+1:2];
    assign o_badaddr  = o_exc ? r_addr : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a BRAM model.
// Override MEM_LATENCY (1 or 2) to cover both BRAM modes.
module tb_mem_access_unit;
    parameter int MEM_LATENCY = 2;
    localparam int RAM_DEPTH = 2048;
    localparam int AW = $clog2(RAM_DEPTH - 1);

    typedef struct {
        int            kind;
        logic [31:0]   data;
        int            lat;
        logic [3:0]    we;
        logic [31:0]   wd;
        logic [AW-1:0] ma;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic          i_we;
    logic [2:0]    i_op;
    logic [31:0]   i_addr;
    logic [31:0]   i_wdata;
    logic [31:0]   o_rdata;
    logic          o_rvalid;
    logic          o_done;
    logic          o_exc;
    logic [31:0]   o_badaddr;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_we;
    logic          o_mem_en;
    logic          o_mem_rea;
    logic [31:0]   mem_rdata;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    bit [7:0] refb [0:255];

    mem_access_unit #(
        .NB_DATA(32),
        .RAM_DEPTH(RAM_DEPTH),
        .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_we(i_we),
        .i_op(i_op),
        .i_addr(i_addr),
        .i_wdata(i_wdata),
        .o_rdata(o_rdata),
        .o_rvalid(o_rvalid),
        .o_done(o_done),
        .o_exc(o_exc),
        .o_badaddr(o_badaddr),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_we(o_mem_we),
        .o_mem_en(o_mem_en),
        .o_mem_rea(o_mem_rea),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM: read-first, output pipeline of MEM_LATENCY stages.
    bit [31:0] bram [0:RAM_DEPTH-1];
    bit [31:0] pipe [MEM_LATENCY];
    always @(posedge clk) begin
        if (o_mem_en) begin
            for (int k = MEM_LATENCY - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= bram[o_mem_addr];
            for (int b = 0; b < 4; b++)
                if (o_mem_we[b]) bram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = pipe[MEM_LATENCY-1];

    function automatic exp_t make_exp(input logic we, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int sz;
        logic [31:0] ea, v;
        e = '{kind: 0, data: 0, lat: 0, we: 0, wd: 0, ma: 0};
        sz = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        ea = a;
        if ((a & 32'(sz - 1)) != 0) begin
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
            e.kind = 2;
            e.data = a;
            e.lat = 1;
            return e;
`else
            ea = a & ~32'(sz - 1);
`endif
        end
        e.ma = ea[AW+1:2];
        if (we) begin
            e.kind = 0;
            e.lat = 2;
            for (int i = 0; i < sz; i++) begin
                e.we[int'(ea[1:0]) + i] = 1'b1;
                refb[int'(ea[7:0]) + i] = d[8*i +: 8];
            end
            for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = d[8*(k % sz) +: 8];
        end else begin
            e.kind = 1;
            e.lat = MEM_LATENCY + 2;
            v = 0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = refb[int'(ea[7:0]) + i];
            if (sz < 4 && !op[2] && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            e.data = v;
        end
        return e;
    endfunction

    task automatic accept(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, output int acc);
        int t;
        t = 0;
        i_valid = 1'b1;
        i_we = we;
        i_op = op;
        i_addr = a;
        i_wdata = d;
        @(negedge clk);
        while (!o_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: o_ready=%b want 1", o_ready);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        i_we = 1'($urandom);
        i_op = 3'($urandom);
        i_addr = $urandom;
        i_wdata = $urandom;
    endtask

    task automatic collect();
        exp_t e;
        int n;
        logic got, rdy_seen, en_seen, en1;
        logic [3:0] we1;
        logic [31:0] wd1;
        logic [AW-1:0] ma1;
        logic [2:0] pulses, want;
        n = 0; got = 0; rdy_seen = 0; en_seen = 0; en1 = 0;
        we1 = 0; wd1 = 0; ma1 = 0; pulses = 0;
        e = sb.pop_front();
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (o_ready) rdy_seen = 1;
            if (o_mem_en) en_seen = 1;
            if (n == 1) begin
                en1 = o_mem_en; we1 = o_mem_we; wd1 = o_mem_wdata; ma1 = o_mem_addr;
            end
            pulses = {o_rvalid, o_done, o_exc};
            if (pulses != 3'b000) got = 1;
        end
        case (e.kind)
            0: want = 3'b010;
            1: want = 3'b100;
            default: want = 3'b001;
        endcase
        checks++;
        if (!got || n != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles (seen=%b) want %0d", n, got, e.lat);
        end
        checks++;
        if (pulses !== want) begin
            errors++;
            $display("FAIL pulses: got rvalid/done/exc=%b want %b", pulses, want);
        end
        checks++;
        if (rdy_seen !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: o_ready high while busy, want low");
        end
        if (e.kind == 0) begin
            checks++;
            if (we1 !== e.we) begin
                errors++;
                $display("FAIL store_we: got %b want %b", we1, e.we);
            end
            checks++;
            if (wd1 !== e.wd) begin
                errors++;
                $display("FAIL store_wdata: got %h want %h", wd1, e.wd);
            end
            checks++;
            if ({en1, ma1} !== {1'b1, e.ma}) begin
                errors++;
                $display("FAIL store_addr: got en=%b addr=%h want en=1 addr=%h", en1, ma1, e.ma);
            end
        end else if (e.kind == 1) begin
            checks++;
            if (o_rdata !== e.data) begin
                errors++;
                $display("FAIL load_data: got %h want %h", o_rdata, e.data);
            end
            checks++;
            if ({en1, we1, ma1} !== {1'b1, 4'b0000, e.ma}) begin
                errors++;
                $display("FAIL load_issue: got en=%b we=%b addr=%h want en=1 we=0000 addr=%h",
                         en1, we1, ma1, e.ma);
            end
        end else begin
            checks++;
            if (o_badaddr !== e.data) begin
                errors++;
                $display("FAIL badaddr: got %h want %h", o_badaddr, e.data);
            end
            checks++;
            if (en_seen !== 1'b0) begin
                errors++;
                $display("FAIL exc_mem_en: got o_mem_en=1 want 0");
            end
        end
    endtask

    task automatic run(input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input exp_t e, input logic hold, output int acc);
        sb.push_back(e);
        accept(we, op, a, d, acc);
        collect();
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_valid = 1'b0; i_we = 1'b0; i_op = 3'b000; i_addr = 0; i_wdata = 0;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (o_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got %b want 1", p, o_ready);
            end
            checks++;
            if ({o_rdata, o_rvalid, o_done, o_exc, o_badaddr, o_mem_addr,
                 o_mem_wdata, o_mem_we, o_mem_en, o_mem_rea} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got rdata=%h rv=%b dn=%b exc=%b bad=%h ma=%h wd=%h we=%b en=%b rea=%b want all 0",
                         p, o_rdata, o_rvalid, o_done, o_exc, o_badaddr, o_mem_addr,
                         o_mem_wdata, o_mem_we, o_mem_en, o_mem_rea);
            end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_word();
        exp_t e;
        int acc;
        e = make_exp(1'b1, 3'b011, 32'h10, 32'h11223344);
        e.we = 4'b1111; e.wd = 32'h11223344; e.ma = 4;
        run(1'b1, 3'b011, 32'h10, 32'h11223344, e, 1'b0, acc);
        e = make_exp(1'b0, 3'b011, 32'h10, 32'h0);
        e.data = 32'h11223344;
        run(1'b0, 3'b011, 32'h10, 32'h0, e, 1'b0, acc);
    endtask

    task automatic test_byte();
        exp_t e;
        int acc;
        e = make_exp(1'b1, 3'b000, 32'h13, 32'h123456A5);
        e.we = 4'b1000; e.wd = 32'hA5A5A5A5;
        run(1'b1, 3'b000, 32'h13, 32'h123456A5, e, 1'b0, acc);
        e = make_exp(1'b0, 3'b000, 32'h13, 32'h0);
        e.data = 32'hFFFFFFA5;
        run(1'b0, 3'b000, 32'h13, 32'h0, e, 1'b0, acc);
        e = make_exp(1'b0, 3'b100, 32'h13, 32'h0);
        e.data = 32'h000000A5;
        run(1'b0, 3'b100, 32'h13, 32'h0, e, 1'b0, acc);
    endtask

    task automatic test_half();
        exp_t e;
        int acc;
        e = make_exp(1'b1, 3'b001, 32'h12, 32'hCAFE8001);
        e.we = 4'b1100; e.wd = 32'h80018001;
        run(1'b1, 3'b001, 32'h12, 32'hCAFE8001, e, 1'b0, acc);
        e = make_exp(1'b0, 3'b001, 32'h12, 32'h0);
        e.data = 32'hFFFF8001;
        run(1'b0, 3'b001, 32'h12, 32'h0, e, 1'b0, acc);
        e = make_exp(1'b0, 3'b101, 32'h12, 32'h0);
        e.data = 32'h00008001;
        run(1'b0, 3'b101, 32'h12, 32'h0, e, 1'b0, acc);
        e = make_exp(1'b1, 3'b000, 32'h20, 32'h77);
        run(1'b1, 3'b000, 32'h20, 32'h77, e, 1'b0, acc);
        checks++;
        if (o_rdata !== 32'h00008001) begin
            errors++;
            $display("FAIL rdata_hold: got %h want 00008001", o_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic        bw [7];
        logic [2:0]  bo [7];
        logic [31:0] ba [7];
        logic [31:0] bd [7];
        logic [31:0] bx [7];
        int acc, prev, gap;
        exp_t e;
        bw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bo = '{3'b011, 3'b011, 3'b000, 3'b100, 3'b111, 3'b100, 3'b110};
        ba = '{32'h40, 32'h40, 32'h41, 32'h41, 32'h40, 32'h42, 32'h40};
        bd = '{32'hDEADBEEF, 32'h0, 32'hFFFFFF5A, 32'h0, 32'h0, 32'h00000033, 32'h0};
        bx = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0000005A, 32'hDEAD5AEF, 32'h0, 32'hDE335AEF};
        prev = 0;
        gap = 0;
        for (int i = 0; i < 7; i++) begin
            e = make_exp(bw[i], bo[i], ba[i], bd[i]);
            if (!bw[i]) e.data = bx[i];
            if (i == 5) begin
                e.we = 4'b0100; e.wd = 32'h33333333;
            end
            run(bw[i], bo[i], ba[i], bd[i], e, 1'b1, acc);
            if (i > 0) begin
                checks++;
                if (acc - prev !== gap) begin
                    errors++;
                    $display("FAIL throughput[%0d]: got %0d cycles want %0d", i, acc - prev, gap);
                end
            end
            prev = acc;
            gap = bw[i] ? 3 : MEM_LATENCY + 3;
        end
        i_valid = 1'b0;
    endtask

    task automatic test_misalign();
        exp_t e;
        int acc;
        e = make_exp(1'b0, 3'b011, 32'h11, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        e.data = 32'h00000011;
`else
        e.data = 32'h80013344;
        e.ma = 4;
`endif
        run(1'b0, 3'b011, 32'h11, 32'h0, e, 1'b0, acc);
        e = make_exp(1'b1, 3'b001, 32'h8000_0023, 32'h0000BEEF);
        run(1'b1, 3'b001, 32'h8000_0023, 32'h0000BEEF, e, 1'b0, acc);
        e = make_exp(1'b0, 3'b011, 32'h20, 32'h0);
        run(1'b0, 3'b011, 32'h20, 32'h0, e, 1'b0, acc);
    endtask

    task automatic test_random();
        exp_t e;
        int acc;
        logic we;
        logic [2:0] op;
        logic [31:0] r, a, d;
        for (int k = 0; k < 30; k++) begin
            we = 1'($urandom);
            op = 3'($urandom);
            r = $urandom;
            a = {r[31:13], 5'b00000, 8'($urandom)};
            d = $urandom;
            e = make_exp(we, op, a, d);
            run(we, op, a, d, e, 1'($urandom), acc);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc;
        logic seen;
        accept(1'b0, 3'b011, 32'h10, 32'h0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_rvalid, o_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset_state: got ready=%b rvalid=%b rdata=%h want 1 0 0",
                     o_ready, o_rvalid, o_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (MEM_LATENCY + 4) begin
            @(negedge clk);
            if (o_rvalid || o_done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pulse: got pulse=%b ready=%b want 0 1", seen, o_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_back_to_back();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
